// File: rtl/layer_test_pkg.sv
// Shared types and helpers for the layer test scheduler.
package layer_test_pkg;

   localparam int unsigned DEFAULT_RES_W = 8;
   localparam int unsigned MAX_LAYERS    = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_SHIFT,
      S_NEXT,
      S_DONE
   } sched_state_t;

   // One-hot vector with bit idx set; all-zero when idx is out of range.
   function automatic logic [MAX_LAYERS-1:0] onehot(input int unsigned idx);
      return MAX_LAYERS'(1) << idx;
   endfunction

endpackage

// File: rtl/layer_test_sched_result_serializer.sv
// Loads a layer result word and shifts it out MSB first, one bit per cycle,
// with data_valid high for exactly RES_W cycles.
module result_serializer
   import layer_test_pkg::*;
#(
   parameter int unsigned RES_W = DEFAULT_RES_W
) (
   input  logic             t_clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [RES_W-1:0] i_data,
   output logic             o_data_out,
   output logic             o_data_valid,
   output logic             o_last
);

   localparam int unsigned BCNT_W = $clog2(RES_W + 1);

   logic [RES_W-1:0]  r_sreg;
   logic [BCNT_W-1:0] r_bcnt;
   logic              r_data_out;
   logic              r_valid;

   // The MSB is presented in the load cycle itself so the first bit appears
   // one cycle after the finish is sampled; r_bcnt counts bits already shown.
   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg     <= '0;
         r_bcnt     <= '0;
         r_data_out <= 1'b0;
         r_valid    <= 1'b0;
      end else if (i_load) begin
         r_sreg     <= i_data << 1;
         r_data_out <= i_data[RES_W-1];
         r_valid    <= 1'b1;
         r_bcnt     <= BCNT_W'(1);
      end else if (r_valid) begin
         if (r_bcnt == BCNT_W'(RES_W)) begin
            r_valid    <= 1'b0;
            r_data_out <= 1'b0;
            r_bcnt     <= '0;
         end else begin
            r_data_out <= r_sreg[RES_W-1];
            r_sreg     <= r_sreg << 1;
            r_bcnt     <= r_bcnt + BCNT_W'(1);
         end
      end
   end

   assign o_data_out   = r_data_out;
   assign o_data_valid = r_valid;
   assign o_last       = r_valid && (r_bcnt == BCNT_W'(RES_W));

endmodule

// File: rtl/layer_test_sched.sv
// Per-layer self-test sequencer: enables one layer at a time, waits for its
// finish, serialises its result word, then moves on to the next layer.
// Optional feature macro: SCHED_TIMEOUT_EN (WAIT timeout and timeout_flag).
module layer_test_sched
   import layer_test_pkg::*;
#(
   parameter int unsigned N_LAYERS = 2,
   parameter int unsigned RES_W    = DEFAULT_RES_W,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                      t_clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [N_LAYERS-1:0]       sort_finish,
   input  logic [N_LAYERS*RES_W-1:0] res_data,
   output logic [N_LAYERS-1:0]       f_layer,
   output logic                      data_out,
   output logic                      data_valid,
   output logic                      busy,
   output logic                      done,
   output logic [N_LAYERS-1:0]       timeout_flag
);

   localparam int unsigned IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

   if (N_LAYERS < 1 || N_LAYERS > MAX_LAYERS) begin : g_bad_layers
      $error("N_LAYERS out of range");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end
   if (RES_W < 1) begin : g_bad_resw
      $error("RES_W must be at least 1");
   end

   sched_state_t        r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;
   logic [N_LAYERS-1:0] r_f_layer, w_f_layer_nxt;
   logic                w_fin_sel;
   logic [RES_W-1:0]    w_res_sel;
   logic                w_load;
   logic                w_last;
   logic [N_LAYERS-1:0] w_onehot;

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0]    r_wcnt, w_wcnt_nxt;
   logic [N_LAYERS-1:0] r_tflag, w_tflag_nxt;
`endif

   assign w_onehot = N_LAYERS'(onehot(32'(r_idx)));

   // Select the finish bit and result word of the layer currently scheduled.
   always_comb begin
      w_fin_sel = 1'b0;
      w_res_sel = '0;
      for (int unsigned k = 0; k < N_LAYERS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_fin_sel = sort_finish[k];
            w_res_sel = res_data[k*RES_W +: RES_W];
         end
      end
   end

   // Next-state and next-datapath values for the sweep sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_f_layer_nxt = r_f_layer;
      w_load        = 1'b0;
`ifdef SCHED_TIMEOUT_EN
      w_wcnt_nxt    = r_wcnt;
      w_tflag_nxt   = r_tflag;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_ARM;
               w_idx_nxt   = '0;
`ifdef SCHED_TIMEOUT_EN
               w_tflag_nxt = '0;
`endif
            end
         end
         S_ARM: begin
            w_f_layer_nxt = w_onehot;
`ifdef SCHED_TIMEOUT_EN
            w_wcnt_nxt    = '0;
`endif
            w_state_nxt   = S_WAIT;
         end
         S_WAIT: begin
            // Finish is tested first so it beats a simultaneous timeout.
            if (w_fin_sel) begin
               w_load        = 1'b1;
               w_f_layer_nxt = '0;
               w_state_nxt   = S_SHIFT;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (r_wcnt == CNT_W'(TIMEOUT - 1)) begin
               w_tflag_nxt   = r_tflag | w_onehot;
               w_f_layer_nxt = '0;
               w_state_nxt   = S_NEXT;
            end else begin
               w_wcnt_nxt = r_wcnt + CNT_W'(1);
            end
`endif
         end
         S_SHIFT: begin
            if (w_last) begin
               w_state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (r_idx == IDX_W'(N_LAYERS - 1)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_state_nxt = S_ARM;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers of the sequencer.
   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_f_layer <= '0;
`ifdef SCHED_TIMEOUT_EN
         r_wcnt    <= '0;
         r_tflag   <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_f_layer <= w_f_layer_nxt;
`ifdef SCHED_TIMEOUT_EN
         r_wcnt    <= w_wcnt_nxt;
         r_tflag   <= w_tflag_nxt;
`endif
      end
   end

   result_serializer #(
      .RES_W(RES_W)
   ) u_ser (
      .t_clk       (t_clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_data      (w_res_sel),
      .o_data_out  (data_out),
      .o_data_valid(data_valid),
      .o_last      (w_last)
   );

   assign f_layer = r_f_layer;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
`ifdef SCHED_TIMEOUT_EN
   assign timeout_flag = r_tflag;
`else
   assign timeout_flag = '0;
`endif

endmodule
